// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if
//
// Bundles the selection controls, the per-channel input handshake and the
// single output handshake of rr_mux_arbiter.
//
// Parameters:
//   WIDTH    - data bits per channel
//   CHANNELS - number of input channels
//   ADDR_W   - channel index width, max(1, $clog2(CHANNELS)) (derived)
//
// Signals:
//   mode      - 0 = addressed select, 1 = round-robin
//   addr      - channel select used in addressed mode
//   in_data   - channel i occupies [i*WIDTH +: WIDTH]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready, at most one bit high
//   out_data  - registered data of the selected beat
//   out_chan  - index of the channel that supplied out_data
//   out_valid - output register holds a beat
//   out_ready - consumer accepts the held beat
//
// Modports:
//   master - the arbiter itself (owns in_ready and the output register)
//   slave  - the surrounding producers/consumer
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int ADDR_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                      mode;
  logic [ADDR_W-1:0]         addr;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [ADDR_W-1:0]         out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    input  mode,
    input  addr,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output mode,
    output addr,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Registered N-channel multiplexer with valid/ready handshakes. Each cycle one
// channel is granted, either by explicit address (mode=0) or by round-robin
// search starting after the last granted channel (mode=1). The granted beat
// is captured into a single output register; a beat may be loaded on the
// same edge the previous one is consumed, so throughput is one beat/cycle.
//
// Ports:
//   clk   - sole clock, all state on the rising edge
//   rst_n - asynchronous, active-low reset
//   bus   - rr_mux_arbiter_if.master (select controls, input channels,
//           output register handshake)
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_mux_arbiter_if.master bus
);

  localparam int                ADDR_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_W-1:0] LAST_CHAN = ADDR_W'(CHANNELS - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              run_reg;
  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  out_data_reg,  out_data_next;
  logic [ADDR_W-1:0] out_chan_reg,  out_chan_next;
  logic [ADDR_W-1:0] ptr_reg,       ptr_next;

  // -------------------------------------------------------------------------
  // Grant path
  // -------------------------------------------------------------------------
  logic                load_ok;
  logic                rr_found;
  logic [ADDR_W-1:0]   rr_grant;
  logic                addr_in_range;
  logic [ADDR_W-1:0]   grant;
  logic                grant_exists;
  logic [CHANNELS-1:0] ready_vec;
  logic [CHANNELS-1:0] xfer_vec;
  logic                any_xfer;
  logic [WIDTH-1:0]    xfer_data;

  // Channel reached `step` positions after `base`, wrapping at CHANNELS.
  // base < CHANNELS and step <= CHANNELS, so one subtraction is enough.
  function automatic logic [ADDR_W-1:0] rr_index(input logic [ADDR_W-1:0] base,
                                                 input int                step);
    int s;
    s = int'(base) + step;
    if (s >= CHANNELS) begin
      s = s - CHANNELS;
    end
    return ADDR_W'(s);
  endfunction

  // The output register can take a new beat when it is empty or being
  // drained on this same edge. run_reg keeps all grants off for the first
  // edge after reset release.
  assign load_ok = run_reg & (~out_valid_reg | bus.out_ready);

  // Round-robin search: walk from the farthest candidate back to the
  // nearest so the nearest valid channel after ptr is the one that sticks.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      if (bus.in_valid[rr_index(ptr_reg, k)]) begin
        rr_found = 1'b1;
        rr_grant = rr_index(ptr_reg, k);
      end
    end
  end

  // An address can only be out of range when CHANNELS is not a power of two.
  generate
    if ((1 << ADDR_W) > CHANNELS) begin : g_addr_chk
      assign addr_in_range = (int'(bus.addr) < CHANNELS);
    end else begin : g_addr_full
      assign addr_in_range = 1'b1;
    end
  endgenerate

  assign grant        = bus.mode ? rr_grant : bus.addr;
  assign grant_exists = bus.mode ? rr_found : addr_in_range;

  // One-hot ready. In addressed mode the granted channel may be idle, so a
  // transfer needs both ready and valid.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign ready_vec[gi] = load_ok & grant_exists & (grant == ADDR_W'(gi));
      assign xfer_vec[gi]  = ready_vec[gi] & bus.in_valid[gi];
    end
  endgenerate

  assign any_xfer = |xfer_vec;

  // AND-OR data select driven by the one-hot transfer vector; avoids
  // indexing past the last channel when CHANNELS is not a power of two.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (xfer_vec[i]) begin
        xfer_data = xfer_data | bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    ptr_next       = ptr_reg;

    if (any_xfer) begin
      // New beat replaces the held one even if that one is leaving now.
      out_valid_next = 1'b1;
      out_data_next  = xfer_data;
      out_chan_next  = grant;
      ptr_next       = grant;
    end else if (out_valid_reg && bus.out_ready) begin
      // Data and channel stay as they were; only the valid flag drops.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= LAST_CHAN;   // channel 0 gets first priority
    end else begin
      run_reg       <= 1'b1;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      ptr_reg       <= ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Three instances: A (WIDTH=8, CHANNELS=4) is the main target with a
// behavioural reference model; B (WIDTH=1, CHANNELS=4) runs the exhaustive
// addressed sweep; C (WIDTH=8, CHANNELS=3) covers out-of-range addresses and
// round-robin wrap with a non power-of-two channel count.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  rr_mux_arbiter_if #(.WIDTH(1), .CHANNELS(4)) bus_b ();
  rr_mux_arbiter_if #(.WIDTH(8), .CHANNELS(3)) bus_c ();

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  rr_mux_arbiter #(.WIDTH(1), .CHANNELS(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));
  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.master));

  // Reference model state for instance A
  bit         m_run;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_oc;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Grant rule: addressed picks addr if it names a real channel; round-robin
  // takes the first valid channel after ptr, wrapping. -1 means no grant.
  function automatic int exp_grant(input int ch, input bit md, input int ad,
                                   input logic [7:0] vld, input int ptr);
    if (!md) return (ad < ch) ? ad : -1;
    for (int k = 1; k <= ch; k++) begin
      int c;
      c = (ptr + k) % ch;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  // One clock of instance A: check ready against the model before the edge,
  // advance the model, then check the registered outputs after the edge.
  task automatic cycle_a();
    int         g;
    bit         lok;
    logic [3:0] exp_ir;
    #1;
    g      = exp_grant(4, bus_a.mode, int'(bus_a.addr), {4'b0, bus_a.in_valid}, m_ptr);
    lok    = m_run && (!m_ov || bus_a.out_ready);
    exp_ir = (lok && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("a_in_ready", 32'(bus_a.in_ready), 32'(exp_ir));
    if (exp_ir != 4'b0 && bus_a.in_valid[g]) begin
      m_od  = bus_a.in_data[g*8 +: 8];
      m_oc  = g;
      m_ov  = 1'b1;
      m_ptr = g;
    end else if (m_ov && bus_a.out_ready) begin
      m_ov = 1'b0;
    end
    m_run = 1'b1;
    @(posedge clk);
    #1;
    chk("a_out_valid", 32'(bus_a.out_valid), 32'(m_ov));
    chk("a_out_data",  32'(bus_a.out_data),  32'(m_od));
    chk("a_out_chan",  32'(bus_a.out_chan),  32'(m_oc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    m_run = 1'b0; m_ov = 1'b0; m_od = 8'h00; m_oc = 0; m_ptr = 3;

    bus_a.mode = 1'b1; bus_a.addr = 2'd0; bus_a.in_valid = 4'hF; bus_a.out_ready = 1'b1;
    bus_a.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus_b.mode = 1'b0; bus_b.addr = 2'd0; bus_b.in_valid = 4'h0; bus_b.out_ready = 1'b0;
    bus_b.in_data = 4'h0;
    bus_c.mode = 1'b0; bus_c.addr = 2'd0; bus_c.in_valid = 3'h0; bus_c.out_ready = 1'b0;
    bus_c.in_data = {8'h22, 8'h21, 8'h20};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("a_rst_data",  32'(bus_a.out_data),  32'd0);
    chk("a_rst_chan",  32'(bus_a.out_chan),  32'd0);
    chk("a_rst_ready", 32'(bus_a.in_ready),  32'd0);

    // ---- release: no grant on first edge, ch0 first, valid after 2nd edge ----
    rst_n = 1'b1;
    cycle_a();
    chk("a_first_edge_valid", 32'(bus_a.out_valid), 32'd0);
    cycle_a();
    chk("a_first_beat_chan", 32'(bus_a.out_chan), 32'd0);
    chk("a_first_beat_data", 32'(bus_a.out_data), 32'h10);

    // ---- round-robin sweep, one beat per cycle ----
    for (int k = 1; k < 7; k++) begin
      cycle_a();
      chk("a_rr_data", 32'(bus_a.out_data), 32'(8'h10 + 8'(k % 4)));
      chk("a_rr_chan", 32'(bus_a.out_chan), 32'(k % 4));
    end

    // ---- backpressure while 0x12 from ch2 is held ----
    bus_a.out_ready = 1'b0;
    repeat (3) begin
      cycle_a();
      chk("a_stall_data",  32'(bus_a.out_data),  32'h12);
      chk("a_stall_chan",  32'(bus_a.out_chan),  32'd2);
      chk("a_stall_ready", 32'(bus_a.in_ready),  32'd0);
    end
    bus_a.out_ready = 1'b1;
    cycle_a();
    chk("a_release_data", 32'(bus_a.out_data), 32'h13);

    // ---- sparse: ptr=3, only ch2 valid ----
    bus_a.in_valid = 4'b0100;
    cycle_a();
    chk("a_sparse_chan", 32'(bus_a.out_chan), 32'd2);

    // ---- mode switch ----
    bus_a.in_valid = 4'b0010;
    cycle_a();
    chk("a_sw_rr_chan", 32'(bus_a.out_chan), 32'd1);
    bus_a.mode = 1'b0; bus_a.addr = 2'd3; bus_a.in_valid = 4'hF;
    cycle_a();
    chk("a_sw_addr_chan", 32'(bus_a.out_chan), 32'd3);
    chk("a_sw_addr_data", 32'(bus_a.out_data), 32'h13);
    bus_a.mode = 1'b1;
    cycle_a();
    chk("a_sw_back_chan", 32'(bus_a.out_chan), 32'd0);

    // ---- addressed grant on an idle channel: ready but no transfer ----
    bus_a.mode = 1'b0; bus_a.addr = 2'd1; bus_a.in_valid = 4'b1101;
    cycle_a();
    chk("a_idle_addr_valid", 32'(bus_a.out_valid), 32'd0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 300; n++) begin
      bus_a.mode      = 1'($urandom_range(0, 1));
      bus_a.addr      = 2'($urandom_range(0, 3));
      bus_a.in_valid  = 4'($urandom);
      bus_a.in_data   = $urandom;
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      cycle_a();
    end

    // ---- B: exhaustive addressed, WIDTH=1 ----
    bus_b.mode = 1'b0; bus_b.in_valid = 4'hF; bus_b.out_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      for (int a = 0; a < 4; a++) begin
        bus_b.in_data = 4'(p);
        bus_b.addr    = 2'(a);
        @(posedge clk);
        #1;
        chk("b_data", 32'(bus_b.out_data), 32'((p >> a) & 1));
        chk("b_chan", 32'(bus_b.out_chan), 32'(a));
      end
    end

    // ---- C: CHANNELS=3, addr=3 is out of range ----
    bus_c.mode = 1'b0; bus_c.addr = 2'd3; bus_c.in_valid = 3'b111; bus_c.out_ready = 1'b1;
    repeat (3) begin
      #1;
      chk("c_oor_ready", 32'(bus_c.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("c_oor_valid", 32'(bus_c.out_valid), 32'd0);
    end
    // Round-robin wrap over three channels, ptr starts at 2
    bus_c.mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("c_rr_chan", 32'(bus_c.out_chan), 32'(k % 3));
      chk("c_rr_data", 32'(bus_c.out_data), 32'(8'h20 + 8'(k % 3)));
    end

    // ---- asynchronous reset while a beat is held ----
    bus_a.mode = 1'b1; bus_a.in_valid = 4'hF; bus_a.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("a_hold_before_rst", 32'(bus_a.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("a_async_rst_ready", 32'(bus_a.in_ready),  32'd0);
    chk("a_async_rst_data",  32'(bus_a.out_data),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. Selects one input channel per cycle, either by an explicit address (addressed mode, the classic mux function) or by round-robin arbitration among valid channels. The selected beat is captured into a single output register. Sits between multiple producers and one consumer in the datapath, replacing the purely combinational 4:1 mux where backpressure and fair sharing are required.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>= 1)
- CHANNELS, 4, number of input channels (>= 2)
- ADDR_W, max(1, $clog2(CHANNELS)), channel index width (derived, not overridden)

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- mode  in  1  0 = addressed, 1 = round-robin
- addr  in  ADDR_W  channel select in addressed mode; ignored in round-robin
- in_data  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; at most one bit high per cycle
- out_data  out  WIDTH  registered selected data
- out_chan  out  ADDR_W  index of channel that supplied out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts beat

## Operation
- load_ok = run & (!out_valid | out_ready). run is a register cleared by reset and set on the first clk edge after rst_n rises.
- Grant (combinational):
  - Addressed: grant = addr. No grant if addr >= CHANNELS.
  - Round-robin: search channels ptr+1, ptr+2, … (mod CHANNELS) for the first with in_valid set. No grant if none are valid.
- in_ready[i] = load_ok & grant_exists & (grant == i).
  - Addressed mode: in_ready[addr] may be high while in_valid[addr] is low.
  - Round-robin: in_ready is only ever high on a valid channel.
- Input transfer on channel i: in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data[i]
  - out_chan <= i
  - out_valid <= 1
  - ptr <= i, in both modes
- Output transfer: out_valid & out_ready. If no input transfer occurs on the same edge, out_valid <= 0. out_data and out_chan keep their last value.
- Simultaneous input and output transfer: the register is overwritten with the new beat and out_valid stays 1. No bubble.
- While out_valid & !out_ready:
  - out_data and out_chan are held stable.
  - All in_ready are low.
- Mode or addr changes take effect combinationally for the next grant. They never disturb a beat already held in the output register.
- Reset values: out_valid 0, out_data 0, out_chan 0, ptr CHANNELS-1 (so channel 0 has first priority), run 0. in_ready is all 0 while rst_n is low and on the first edge after release.
- Reset asserted mid-operation: the held beat is discarded immediately (asynchronous). No partial state survives.

## Timing
- Latency: input transfer at edge N gives out_valid high after edge N; out_data is valid for the consumer from edge N to edge N+1.
- Throughput: one beat per cycle with out_ready held high.
- Round-robin fairness: with all channels continuously valid, each channel is granted exactly once in every CHANNELS consecutive transfers.
- Grant path is combinational from in_valid, mode, addr and ptr. The output path is fully registered.

## Test plan
- Reset: hold a beat with out_ready=0, then pull rst_n low mid-cycle.
  - Required: out_valid=0 and in_ready=0 without waiting for a clock edge.
  - After release with all channels valid and out_ready=1: first grant is ch0; first out_valid is on the second edge.
- Addressed exhaustive, WIDTH=1, CHANNELS=4: all 16 input patterns × 4 addr values, all in_valid=1, out_ready=1.
  - Required: out_data == in_data[addr] and out_chan == addr, one cycle after each change.
- Round-robin sweep, WIDTH=8: all 4 channels valid, channel i data = 0x10+i, out_ready=1.
  - Required output sequence: 0x10, 0x11, 0x12, 0x13, 0x10 …, with out_chan 0, 1, 2, 3, 0, one beat per cycle.
- Backpressure: stall out_ready=0 for 3 cycles while 0x12 from ch2 is held.
  - Required: out_data=0x12 and out_chan=2 stable; in_ready=0000.
  - Release: the next beat is 0x13; no beat is lost or duplicated.
- Sparse and out-of-range cases:
  - Round-robin, ptr=3, only ch2 valid: grant ch2.
  - CHANNELS=3, addressed mode, addr=3: in_ready=000 and out_valid stays 0.
- Mode switch: in round-robin after ch1 is granted, switch to mode=0 with addr=3.
  - Required: next beat comes from ch3.
  - Switch back to mode=1: next grant is ch0, because ptr was updated to 3.
